// File: rtl/riscv_pkg.sv
// Shared RISC-V decode types: base opcodes, immediate formats and default widths.
// Pure declarations, no logic.
package riscv_pkg;

   localparam int DEF_INST_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;

   typedef enum logic [6:0] {
      LOAD   = 7'b0000011,
      OP_IMM = 7'b0010011,
      AUIPC  = 7'b0010111,
      STORE  = 7'b0100011,
      OP     = 7'b0110011,
      LUI    = 7'b0110111,
      BRANCH = 7'b1100011,
      JALR   = 7'b1100111,
      JAL    = 7'b1101111,
      SYSTEM = 7'b1110011
   } opcode_t;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } imm_fmt_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode -> immediate format/value extraction, sign-extended to RISC_V_DATA_WIDTH.
// Zero latency, no handshake; reusable by the main decoder.
module imm_decode
   import riscv_pkg::*;
#(
   parameter int RISC_V_DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [31:0]                  inst,
   output logic [RISC_V_DATA_WIDTH-1:0] offset,
   output imm_fmt_t                     fmt,
   output logic                         illegal
);

   logic signed [31:0] imm;

   always_comb begin
      imm     = '0;
      fmt     = FMT_R;
      illegal = 1'b0;
      case (opcode_t'(inst[6:0]))
         LOAD, OP_IMM, JALR, SYSTEM: begin
            fmt = FMT_I;
            imm = {{20{inst[31]}}, inst[31:20]};
         end
         STORE: begin
            fmt = FMT_S;
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         end
         BRANCH: begin
            fmt = FMT_B;
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         end
         LUI, AUIPC: begin
            fmt = FMT_U;
            imm = {inst[31:12], 12'b0};
         end
         JAL: begin
            fmt = FMT_J;
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         end
         OP: begin
            fmt = FMT_R;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

   // imm is signed, so widening to 64 bits replicates bit 31
   assign offset = RISC_V_DATA_WIDTH'(imm);

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator behind a valid/ready handshake: output register plus optional skid entry.
// 1-cycle latency into an empty output; back-pressure stalls without drop/duplicate (in_ready registered when SKID_DEPTH=1).
module imm_gen_pipe
   import riscv_pkg::*;
#(
   parameter int INST_WIDTH        = DEF_INST_WIDTH,
   parameter int RISC_V_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int SKID_DEPTH        = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [INST_WIDTH-1:0]        instruction,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [RISC_V_DATA_WIDTH-1:0] offset,
   output imm_fmt_t                     fmt,
   output logic                         illegal
);

   if (INST_WIDTH != 32) begin : g_chk_inst_width
      $error("imm_gen_pipe: INST_WIDTH must be 32");
   end
   if (RISC_V_DATA_WIDTH != 32 && RISC_V_DATA_WIDTH != 64) begin : g_chk_data_width
      $error("imm_gen_pipe: RISC_V_DATA_WIDTH must be 32 or 64");
   end
   if (SKID_DEPTH != 0 && SKID_DEPTH != 1) begin : g_chk_skid_depth
      $error("imm_gen_pipe: SKID_DEPTH must be 0 or 1");
   end

   localparam bit HAS_SKID = (SKID_DEPTH != 0);

   logic [RISC_V_DATA_WIDTH-1:0] dec_offset;
   imm_fmt_t                     dec_fmt;
   logic                         dec_illegal;

   logic                         out_vld_q, out_vld_d;
   logic [RISC_V_DATA_WIDTH-1:0] out_off_q, out_off_d;
   imm_fmt_t                     out_fmt_q, out_fmt_d;
   logic                         out_ill_q, out_ill_d;

   logic                         skid_vld_q, skid_vld_d;
   logic [RISC_V_DATA_WIDTH-1:0] skid_off_q, skid_off_d;
   imm_fmt_t                     skid_fmt_q, skid_fmt_d;
   logic                         skid_ill_q, skid_ill_d;

   // Held low for the first cycle after reset so the block never accepts during reset recovery
   logic                         rdy_q, rdy_d;

   logic                         in_fire;
   logic                         out_fire;

   imm_decode #(
      .RISC_V_DATA_WIDTH(RISC_V_DATA_WIDTH)
   ) u_imm_decode (
      .inst   (instruction[31:0]),
      .offset (dec_offset),
      .fmt    (dec_fmt),
      .illegal(dec_illegal)
   );

   assign in_ready = rdy_q && (HAS_SKID ? !skid_vld_q : (!out_vld_q || out_ready));
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_vld_q && out_ready;

   always_comb begin
      out_vld_d  = out_vld_q;
      out_off_d  = out_off_q;
      out_fmt_d  = out_fmt_q;
      out_ill_d  = out_ill_q;
      skid_vld_d = skid_vld_q;
      skid_off_d = skid_off_q;
      skid_fmt_d = skid_fmt_q;
      skid_ill_d = skid_ill_q;
      rdy_d      = 1'b1;

      if (!out_vld_q || out_fire) begin
         // Output slot frees up: older skid entry has priority over the new input
         if (skid_vld_q) begin
            out_vld_d  = 1'b1;
            out_off_d  = skid_off_q;
            out_fmt_d  = skid_fmt_q;
            out_ill_d  = skid_ill_q;
            skid_vld_d = in_fire;
            if (in_fire) begin
               skid_off_d = dec_offset;
               skid_fmt_d = dec_fmt;
               skid_ill_d = dec_illegal;
            end
         end else if (in_fire) begin
            out_vld_d = 1'b1;
            out_off_d = dec_offset;
            out_fmt_d = dec_fmt;
            out_ill_d = dec_illegal;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (in_fire && HAS_SKID) begin
         skid_vld_d = 1'b1;
         skid_off_d = dec_offset;
         skid_fmt_d = dec_fmt;
         skid_ill_d = dec_illegal;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_q  <= 1'b0;
         out_off_q  <= '0;
         out_fmt_q  <= FMT_R;
         out_ill_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_off_q <= '0;
         skid_fmt_q <= FMT_R;
         skid_ill_q <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_off_q  <= out_off_d;
         out_fmt_q  <= out_fmt_d;
         out_ill_q  <= out_ill_d;
         skid_vld_q <= skid_vld_d;
         skid_off_q <= skid_off_d;
         skid_fmt_q <= skid_fmt_d;
         skid_ill_q <= skid_ill_d;
         rdy_q      <= rdy_d;
      end
   end

   assign out_valid = out_vld_q;
   assign offset    = out_off_q;
   assign fmt       = out_fmt_q;
   assign illegal   = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: formats, 64-bit U sign extension, back-pressure, reset and a random scoreboard run.
module tb_imm_gen_pipe;
   import riscv_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] instruction = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] offset;
   imm_fmt_t    fmt;
   logic        illegal;

   logic        in_valid64 = 1'b0;
   logic        in_ready64;
   logic [31:0] instruction64 = '0;
   logic        out_valid64;
   logic        out_ready64 = 1'b0;
   logic [63:0] offset64;
   imm_fmt_t    fmt64;
   logic        illegal64;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] off;
      imm_fmt_t    fmt;
      logic        ill;
   } vec_t;

   vec_t tbl[9];

   always #5 clk = ~clk;

   imm_gen_pipe #(.INST_WIDTH(32), .RISC_V_DATA_WIDTH(32), .SKID_DEPTH(1)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
      .offset(offset), .fmt(fmt), .illegal(illegal)
   );

   imm_gen_pipe #(.INST_WIDTH(32), .RISC_V_DATA_WIDTH(64), .SKID_DEPTH(1)) dut64 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
      .instruction(instruction64), .out_valid(out_valid64), .out_ready(out_ready64),
      .offset(offset64), .fmt(fmt64), .illegal(illegal64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (3) step();
      checks++;
      if ({out_valid, in_ready, offset, fmt, illegal} !== {1'b0, 1'b0, 32'h0, FMT_R, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got vld=%b rdy=%b off=%h fmt=%0d ill=%b, want 0 0 00000000 0 0",
                  out_valid, in_ready, offset, fmt, illegal);
      end
      rst_n = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_rdy_low: got in_ready=%b want 0", in_ready);
      end
      step();
      checks++;
      if ({in_ready, out_valid, in_ready64} !== 3'b101) begin
         errors++;
         $display("FAIL reset_rdy_high: got rdy=%b vld=%b rdy64=%b want 1 0 1", in_ready, out_valid, in_ready64);
      end
   endtask

   task automatic test_formats();
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         instruction = tbl[i].inst;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL fmt_in_ready[%0d]: got %b want 1", i, in_ready);
         end
         step();
         checks++;
         if ({out_valid, offset, fmt, illegal} !== {1'b1, tbl[i].off, tbl[i].fmt, tbl[i].ill}) begin
            errors++;
            $display("FAIL fmt_vec[%0d]: got vld=%b off=%h fmt=%0d ill=%b want 1 %h %0d %b",
                     i, out_valid, offset, fmt, illegal, tbl[i].off, tbl[i].fmt, tbl[i].ill);
         end
      end
      in_valid = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL fmt_empty: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_u64();
      logic [31:0] vi[3];
      logic [63:0] vo[3];
      imm_fmt_t    vf[3];
      vi[0] = 32'h800000B7; vo[0] = 64'hFFFFFFFF80000000; vf[0] = FMT_U;
      vi[1] = 32'hFFF00093; vo[1] = 64'hFFFFFFFFFFFFFFFF; vf[1] = FMT_I;
      vi[2] = 32'h123450B7; vo[2] = 64'h0000000012345000; vf[2] = FMT_U;
      out_ready64 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_valid64 = 1'b1;
         instruction64 = vi[i];
         step();
         checks++;
         if ({out_valid64, offset64, fmt64, illegal64} !== {1'b1, vo[i], vf[i], 1'b0}) begin
            errors++;
            $display("FAIL u64_vec[%0d]: got vld=%b off=%h fmt=%0d ill=%b want 1 %h %0d 0",
                     i, out_valid64, offset64, fmt64, illegal64, vo[i], vf[i]);
         end
      end
      in_valid64 = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int got = 0;
      int gap = 0;
      bit started = 1'b0;
      out_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         instruction = tbl[acc].inst;
         if (in_ready) acc++;
         step();
      end
      checks++;
      if (acc != 2 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL bp_fill: got accepted=%0d in_ready=%b want 2 0", acc, in_ready);
      end
      out_ready = 1'b1;
      for (int c = 0; c < 20 && got < 4; c++) begin
         in_valid = (acc < 4);
         if (acc < 4) instruction = tbl[acc].inst;
         if (out_valid) begin
            started = 1'b1;
            checks++;
            if ({offset, fmt, illegal} !== {tbl[got].off, tbl[got].fmt, tbl[got].ill}) begin
               errors++;
               $display("FAIL bp_order[%0d]: got off=%h fmt=%0d want %h %0d",
                        got, offset, fmt, tbl[got].off, tbl[got].fmt);
            end
            got++;
         end else if (started) begin
            gap++;
         end
         if (in_valid && in_ready) acc++;
         step();
      end
      in_valid = 1'b0;
      checks++;
      if (got != 4 || gap != 0) begin
         errors++;
         $display("FAIL bp_drain: got outputs=%0d gaps=%0d want 4 0", got, gap);
      end
      step();
   endtask

   task automatic test_stability();
      out_ready = 1'b0;
      in_valid = 1'b1;
      instruction = tbl[2].inst;
      step();
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0];
         instruction = tbl[4 + c].inst;
         checks++;
         if ({out_valid, offset, fmt, illegal} !== {1'b1, tbl[2].off, tbl[2].fmt, tbl[2].ill}) begin
            errors++;
            $display("FAIL stall_hold[%0d]: got vld=%b off=%h fmt=%0d want 1 %h %0d",
                     c, out_valid, offset, fmt, tbl[2].off, tbl[2].fmt);
         end
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      checks++;
      if ({out_valid, offset, fmt} !== {1'b1, tbl[2].off, tbl[2].fmt}) begin
         errors++;
         $display("FAIL stall_release0: got vld=%b off=%h want 1 %h", out_valid, offset, tbl[2].off);
      end
      step();
      checks++;
      if ({out_valid, offset, fmt, illegal} !== {1'b1, tbl[5].off, tbl[5].fmt, tbl[5].ill}) begin
         errors++;
         $display("FAIL stall_release1: got vld=%b off=%h ill=%b want 1 %h %b",
                  out_valid, offset, illegal, tbl[5].off, tbl[5].ill);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_empty: got out_valid=%b want 0", out_valid);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1;
      instruction = tbl[0].inst;
      step();
      instruction = tbl[1].inst;
      step();
      in_valid = 1'b0;
      checks++;
      if ({in_ready, out_valid} !== 2'b01) begin
         errors++;
         $display("FAIL rmid_full: got rdy=%b vld=%b want 0 1", in_ready, out_valid);
      end
      rst_n = 1'b0;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
      checks++;
      if ({out_valid, in_ready} !== 2'b00) begin
         errors++;
         $display("FAIL rmid_after: got vld=%b rdy=%b want 0 0", out_valid, in_ready);
      end
      step();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL rmid_recover: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
      end
      for (int c = 0; c < 3; c++) begin
         step();
         checks++;
         if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_stale[%0d]: got out_valid=%b want 0", c, out_valid);
         end
      end
   endtask

   task automatic test_random();
      int q[$];
      int k;
      int e;
      int held;
      bit hold_chk = 1'b0;
      for (int c = 0; c < 10000; c++) begin
         k = $urandom_range(0, 8);
         in_valid = ($urandom_range(0, 3) != 0);
         instruction = tbl[k].inst;
         out_ready = ($urandom_range(0, 2) != 0);
         if (hold_chk) begin
            checks++;
            if (out_valid !== 1'b1 || {offset, fmt, illegal} !== {tbl[held].off, tbl[held].fmt, tbl[held].ill}) begin
               errors++;
               $display("FAIL rnd_hold[%0d]: got vld=%b off=%h want 1 %h", c, out_valid, offset, tbl[held].off);
            end
         end
         hold_chk = 1'b0;
         if (out_valid && q.size() > 0 && !out_ready) begin
            hold_chk = 1'b1;
            held = q[0];
         end
         if (out_valid && out_ready) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rnd_spurious[%0d]: got output off=%h want none", c, offset);
            end else begin
               e = q.pop_front();
               if ({offset, fmt, illegal} !== {tbl[e].off, tbl[e].fmt, tbl[e].ill}) begin
                  errors++;
                  $display("FAIL rnd_data[%0d]: got off=%h fmt=%0d ill=%b want %h %0d %b",
                           c, offset, fmt, illegal, tbl[e].off, tbl[e].fmt, tbl[e].ill);
               end
            end
         end
         if (in_valid && in_ready) q.push_back(k);
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         if (out_valid && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({offset, fmt, illegal} !== {tbl[e].off, tbl[e].fmt, tbl[e].ill}) begin
               errors++;
               $display("FAIL rnd_drain: got off=%h want %h", offset, tbl[e].off);
            end
         end
         step();
      end
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rnd_leftover: got pending=%0d vld=%b want 0 0", q.size(), out_valid);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{32'hFFC12083, 32'hFFFFFFFC, FMT_I, 1'b0};
      tbl[1] = '{32'hFE112E23, 32'hFFFFFFFC, FMT_S, 1'b0};
      tbl[2] = '{32'hFE000CE3, 32'hFFFFFFF8, FMT_B, 1'b0};
      tbl[3] = '{32'h0010006F, 32'h00000800, FMT_J, 1'b0};
      tbl[4] = '{32'h123450B7, 32'h12345000, FMT_U, 1'b0};
      tbl[5] = '{32'h0000007F, 32'h00000000, FMT_R, 1'b1};
      tbl[6] = '{32'h00000033, 32'h00000000, FMT_R, 1'b0};
      tbl[7] = '{32'h00500093, 32'h00000005, FMT_I, 1'b0};
      tbl[8] = '{32'h00112423, 32'h00000008, FMT_S, 1'b0};

      test_reset();
      test_formats();
      test_u64();
      test_backpressure();
      test_stability();
      test_reset_mid();
      test_random();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, handshaked successor to the single-cycle immediate generator.
- Decodes every RV32I/RV64I immediate format (I, S, B, U, J). Sign-extends to RISC_V_DATA_WIDTH and reports the format and an illegal-opcode flag.
- Sits between fetch/decode and execute as a one-stage pipeline with a skid buffer, so back-pressure from execute never drops or duplicates an instruction.

Parameters:
- INST_WIDTH, 32, instruction width; only 32 is legal (elaboration assertion otherwise).
- RISC_V_DATA_WIDTH, 32, offset width; legal values 32 or 64.
- SKID_DEPTH, 1, extra buffered entries behind the output register; 0 or 1. With 0, in_ready is combinational from out_ready.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  instruction valid.
- in_ready  output  1  block can accept an instruction this cycle.
- instruction  input  INST_WIDTH  raw instruction.
- out_valid  output  1  offset/fmt/illegal valid.
- out_ready  input  1  consumer accepts this cycle.
- offset  output  RISC_V_DATA_WIDTH  signed, sign-extended immediate.
- fmt  output  3  imm_fmt_t: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J.
- illegal  output  1  opcode not in the supported set.

Behaviour:
- Transfer rules: input transfer when in_valid & in_ready. Output transfer when out_valid & out_ready. Strict FIFO ordering; no drops, no duplicates.
- Latency: 1 cycle from input transfer to out_valid when the output register is empty.
- Throughput: 1 instruction per cycle with out_ready held high.
- Opcode-to-format map (instruction[6:0]):
  - LOAD 0000011, OP_IMM 0010011, JALR 1100111, SYSTEM 1110011 -> FMT_I: imm = inst[31:20].
  - STORE 0100011 -> FMT_S: {inst[31:25], inst[11:7]}.
  - BRANCH 1100011 -> FMT_B: {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} (13 bits, bit0 = 0).
  - LUI 0110111, AUIPC 0010111 -> FMT_U: {inst[31:12], 12'b0}.
  - JAL 1101111 -> FMT_J: {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - OP 0110011 -> FMT_R: offset 0, illegal 0.
  - Any other opcode -> FMT_R, offset 0, illegal 1.
- Sign extension: every immediate is sign-extended from its top bit to RISC_V_DATA_WIDTH. For FMT_U with width 64, bits 63:32 replicate inst[31].
- Decode is combinational. Only the decoded result (offset, fmt, illegal) is registered; the raw instruction is not stored.
- Skid (SKID_DEPTH=1):
  - in_ready = !skid_valid (registered).
  - If an input arrives while the output register is full and not draining, the result goes to the skid entry.
  - When the output drains, the skid entry moves into the output register the same cycle. A new input arriving that cycle lands in the skid entry.
- Simultaneous input and output transfer with only the output register full: the new result replaces the output register directly; skid stays empty.
- Full: output and skid both valid -> in_ready = 0; in_valid is ignored.
- Empty: out_valid = 0. offset/fmt/illegal hold their last values, and the bench must not check them.
- Reset (rst_n low at a clock edge):
  - out_valid = 0, skid_valid = 0, in_ready = 0 during reset, offset = 0, fmt = FMT_R, illegal = 0.
  - in_ready = 1 on the first cycle after reset deasserts.
- Reset mid-operation flushes both entries, and the results are lost. No output transfer occurs on the reset cycle.
- out_valid, once asserted, stays high, and its data stays stable, until out_ready is seen high (AXI-style rule).

Decomposition:
- Shared package riscv_pkg:
  - opcode_t enum (extended with OP_IMM, JALR, SYSTEM, LUI, AUIPC, JAL, OP).
  - imm_fmt_t enum.
  - INST_WIDTH and RISC_V_DATA_WIDTH defaults.
- Sub-module imm_decode: purely combinational opcode/format/immediate extraction, parametrised by RISC_V_DATA_WIDTH. It is reusable by the decoder.
- imm_gen_pipe holds the output register, skid entry and handshake logic.

Test Plan:
- Formats, width 32, out_ready=1, one instruction per cycle:
  - 0xFFC12083 (lw) -> 0xFFFFFFFC, FMT_I.
  - 0xFE112E23 (sw) -> 0xFFFFFFFC, FMT_S.
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, FMT_B.
  - 0x0010006F (jal +2048) -> 0x00000800, FMT_J.
  - Each result appears one cycle after acceptance.
- U-type width: 0x123450B7 -> 0x12345000 at width 32. 0x800000B7 at width 64 -> 0xFFFFFFFF80000000, FMT_U.
- Illegal opcode: 0x0000007F -> illegal=1, offset 0, fmt FMT_R. 0x00000033 (add) -> illegal=0, FMT_R.
- Back-pressure:
  - Stream 4 instructions with out_ready=0 -> 2 accepted, then in_ready=0.
  - Raise out_ready -> all 4 outputs in order, no gaps once flowing.
  - Random in_valid/out_ready for 10k cycles, checked against a scoreboard.
- Reset mid-stream: rst_n low for 1 cycle with both entries full -> next cycle out_valid=0 and in_ready=0, then in_ready=1. No stale output afterwards.
- Stability: with out_valid=1 and out_ready=0 for 5 cycles, offset/fmt/illegal stay constant. in_valid toggling during the stall does not alter the output.
